// File: rtl/pf_ram_arbiter.sv
// pf_ram_arbiter: shares the single-port 1Kx8 playfield RAM between the 6502 CPU
// and the video tile fetcher. Each access runs IDLE -> ACC -> DATA; video has
// priority, and the CPU is held off through RDY while it waits.
// Optional starvation guard: define PFARB_STARVE_GUARD_EN to let the CPU win
// after STARVE_MAX consecutive video grants made while it was waiting.
module pf_ram_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ack,
  output logic       cpu_rdy,
  input  logic       vid_req,
  input  logic [9:0] vid_addr,
  output logic [7:0] vid_rdata,
  output logic       vid_ack,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic [7:0] conflict_cnt
);

  typedef enum logic [1:0] {StIdle, StAcc, StData} state_e;

  state_e state_q;
  logic   owner_vid_q;  // 0 = CPU owns the access in flight, 1 = video
  logic   wr_q;         // access in flight is a CPU write
  logic   arb_en;
  logic   both_req;
  logic   starve_hit;
  logic   grant_vid;

`ifdef PFARB_STARVE_GUARD_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  logic [3:0] starve_q;
`else
  logic unused_starve_max;
  assign unused_starve_max = ^(4'(STARVE_MAX));
`endif

  // The CPU is stalled from the moment it requests until its ack cycle.
  assign cpu_rdy = ~cpu_req | cpu_ack;

  // Arbitration: from IDLE on any request; from DATA only when the other side
  // is waiting (the owner's still-high req is the request being acked).
  always_comb begin
    both_req   = cpu_req & vid_req;
    arb_en     = 1'b0;
    starve_hit = 1'b0;
    unique case (state_q)
      StIdle:  arb_en = cpu_req | vid_req;
      StData:  arb_en = owner_vid_q ? cpu_req : vid_req;
      default: arb_en = 1'b0;
    endcase
`ifdef PFARB_STARVE_GUARD_EN
    starve_hit = both_req && (starve_q == StarveMax);
`endif
    grant_vid = vid_req & ~starve_hit;
  end

  // Access sequencer with registered RAM strobes, acks, read data and debug count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_vid_q  <= 1'b0;
      wr_q         <= 1'b0;
      cpu_ack      <= 1'b0;
      vid_ack      <= 1'b0;
      cpu_rdata    <= 8'h00;
      vid_rdata    <= 8'h00;
      ram_addr     <= 10'h000;
      ram_we       <= 1'b0;
      ram_wdata    <= 8'h00;
      conflict_cnt <= 8'h00;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      unique case (state_q)
        StIdle: state_q <= StIdle;
        StAcc: begin
          ram_we  <= 1'b0;
          state_q <= StData;
        end
        StData: begin
          state_q <= StIdle;
          if (owner_vid_q) begin
            vid_rdata <= ram_rdata;
            vid_ack   <= 1'b1;
          end else begin
            if (!wr_q) begin
              cpu_rdata <= ram_rdata;
            end
            cpu_ack <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // A grant overrides the IDLE/DATA next state and launches the next ACC.
      if (arb_en) begin
        state_q     <= StAcc;
        owner_vid_q <= grant_vid;
        wr_q        <= ~grant_vid & cpu_we;
        ram_we      <= ~grant_vid & cpu_we;
        ram_addr    <= grant_vid ? vid_addr : cpu_addr;
        if (!grant_vid && cpu_we) begin
          ram_wdata <= cpu_wdata;
        end
        if (both_req && (conflict_cnt != 8'hFF)) begin
          conflict_cnt <= conflict_cnt + 8'd1;
        end
      end
    end
  end

`ifdef PFARB_STARVE_GUARD_EN
  // Counts video grants that kept a waiting CPU off the RAM; any CPU grant clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'h0;
    end else if (arb_en) begin
      if (!grant_vid) begin
        starve_q <= 4'h0;
      end else if (cpu_req && (starve_q != 4'hF)) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pf_ram_arbiter.sv
// Testbench for pf_ram_arbiter: synchronous 1Kx8 RAM model, directed stimulus,
// and a scoreboard monitor that checks every ack and every RAM write strobe
// against queued expectations (data and cycle of arrival).
module tb_pf_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       cpu_ack, cpu_rdy;
  logic       vid_req;
  logic [9:0] vid_addr;
  logic [7:0] vid_rdata;
  logic       vid_ack;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata, ram_rdata;
  logic [7:0] conflict_cnt;

  pf_ram_arbiter #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdy      (cpu_rdy),
    .vid_req      (vid_req),
    .vid_addr     (vid_addr),
    .vid_rdata    (vid_rdata),
    .vid_ack      (vid_ack),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM; default contents addr[7:0] ^ 0xA5, with 0x2A5 preset to 0x5C.
  logic [7:0] mem [1024];
  bit         ram_init = 1'b1;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'hA5;
      mem[10'h2A5] <= 8'h5C;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rsp_t;
  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  rsp_t cpu_q[$];
  rsp_t vid_q[$];
  wr_t  wr_q[$];
  rsp_t ce, ve;
  wr_t  we_e;
  int   checks = 0;
  int   errors = 0;
  bit   sb_off = 1'b0;

`ifdef PFARB_STARVE_GUARD_EN
  localparam int CpuStarveLat = 11;
  localparam int NumVidStream = 5;
  int vid_ofs [6] = '{3, 5, 7, 9, 13, 0};
`else
  localparam int CpuStarveLat = 15;
  localparam int NumVidStream = 6;
  int vid_ofs [6] = '{3, 5, 7, 9, 11, 13};
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!sb_off) begin
        if (cpu_ack) begin
          checks++;
          if (cpu_q.size() == 0) begin
            errors++;
            $display("FAIL cpu_rsp unexpected ack at cyc %0d", cyc);
          end else begin
            ce = cpu_q.pop_front();
            if (cpu_rdata !== ce.data || cyc != ce.cyc) begin
              errors++;
              $display("FAIL cpu_rsp got %h at cyc %0d expected %h at cyc %0d",
                       cpu_rdata, cyc, ce.data, ce.cyc);
            end
          end
        end
        if (vid_ack) begin
          checks++;
          if (vid_q.size() == 0) begin
            errors++;
            $display("FAIL vid_rsp unexpected ack at cyc %0d", cyc);
          end else begin
            ve = vid_q.pop_front();
            if (vid_rdata !== ve.data || cyc != ve.cyc) begin
              errors++;
              $display("FAIL vid_rsp got %h at cyc %0d expected %h at cyc %0d",
                       vid_rdata, cyc, ve.data, ve.cyc);
            end
          end
        end
        if (ram_we) begin
          checks++;
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL ram_write unexpected ram_we at cyc %0d", cyc);
          end else begin
            we_e = wr_q.pop_front();
            if (ram_addr !== we_e.addr || ram_wdata !== we_e.data || cyc != we_e.cyc) begin
              errors++;
              $display("FAIL ram_write got %h/%h at cyc %0d expected %h/%h at cyc %0d",
                       ram_addr, ram_wdata, cyc, we_e.addr, we_e.data, we_e.cyc);
            end
          end
        end
      end
    end
  end

  // One CPU access; req held until ack is seen, rdy must be low for lat cycles.
  task automatic cpu_go(input logic we, input logic [9:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp, input int lat);
    int n;
    int lowc;
    bit seen;
    @(posedge clk);
    #1;
    n = cyc;
    cpu_q.push_back('{data: exp, cyc: n + lat});
    if (we) wr_q.push_back('{addr: addr, data: wd, cyc: n + lat - 2});
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_req   = 1'b1;
    lowc      = 0;
    seen      = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (cpu_ack) seen = 1'b1;
      else if (!cpu_rdy) lowc++;
    end
    cpu_req = 1'b0;
    chk("cpu_ack_seen", 32'(seen), 32'd1);
    chk("cpu_rdy_low_cycles", lowc, lat);
  endtask

  // Video request that drops after hold cycles (before its ack).
  task automatic vid_pulse(input logic [9:0] addr, input int hold, input logic [7:0] exp,
                           input int lat);
    @(posedge clk);
    #1;
    vid_q.push_back('{data: exp, cyc: cyc + lat});
    vid_addr = addr;
    vid_req  = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    vid_req = 1'b0;
  endtask

  // Video request held high until nacks acks have been seen.
  task automatic vid_stream(input logic [9:0] addr, input int nacks);
    int seen;
    @(posedge clk);
    #1;
    vid_addr = addr;
    vid_req  = 1'b1;
    seen     = 0;
    for (int i = 0; i < 200 && seen < nacks; i++) begin
      @(negedge clk);
      if (vid_ack) seen++;
    end
    vid_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (cpu_q.size() + vid_q.size() + wr_q.size()) != 0; i++)
      @(negedge clk);
    chk("queues_drained", 32'(cpu_q.size() + vid_q.size() + wr_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_vid_ack", 32'(vid_ack), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h00);
    chk("rst_vid_rdata", 32'(vid_rdata), 32'h00);
    chk("rst_ram_addr", 32'(ram_addr), 32'h000);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'h00);
    chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 10'h000;
    cpu_wdata = 8'h00;
    vid_req   = 1'b0;
    vid_addr  = 10'h000;
    repeat (3) @(negedge clk);
    check_reset_vals();
    chk("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
    @(posedge clk);
    #1;
    ram_init = 1'b0;
    rst      = 1'b0;

    // Lone CPU read.
    cpu_go(1'b0, 10'h2A5, 8'h00, 8'h5C, 3);
    drain();

    // CPU write: one ram_we cycle, rdata unchanged, then read back.
    cpu_go(1'b1, 10'h010, 8'h91, 8'h5C, 3);
    drain();
    cpu_go(1'b0, 10'h010, 8'h00, 8'h91, 3);
    drain();

    // Both from IDLE: video first, CPU two cycles later once video has dropped.
    fork
      cpu_go(1'b0, 10'h2A5, 8'h00, 8'h5C, 5);
      vid_pulse(10'h123, 1, 8'h86, 3);
    join
    drain();
    chk("conflict_after_simul", 32'(conflict_cnt), 32'd1);

    // Video held high while the CPU waits.
    fork
      cpu_go(1'b0, 10'h2A5, 8'h00, 8'h5C, CpuStarveLat);
      vid_stream(10'h0C7, 5);
      begin
        @(posedge clk);
        #1;
        n = cyc;
        for (int k = 0; k < NumVidStream; k++)
          vid_q.push_back('{data: 8'h62, cyc: n + vid_ofs[k]});
      end
    join
    drain();
    chk("conflict_after_starve", 32'(conflict_cnt), 32'd7);

    // Reset pulsed during the ACC cycle of a CPU write; the held request re-runs.
    fork
      cpu_go(1'b1, 10'h3FF, 8'h77, 8'h00, 4);
      begin
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals();
        #1;
        rst = 1'b0;
      end
    join
    drain();
    cpu_go(1'b0, 10'h3FF, 8'h00, 8'h77, 3);
    drain();
    cpu_go(1'b0, 10'h010, 8'h00, 8'h91, 3);
    drain();
    chk("conflict_before_sat", 32'(conflict_cnt), 32'd0);

    // Continuous conflicts: one arbitration every 2 cycles, saturating at 255.
    sb_off = 1'b1;
    @(posedge clk);
    #1;
    n         = cyc;
    cpu_we    = 1'b0;
    cpu_addr  = 10'h2A5;
    vid_addr  = 10'h123;
    cpu_req   = 1'b1;
    vid_req   = 1'b1;
    for (int i = 0; i < 660; i++) begin
      @(negedge clk);
      if (cyc == n + 199) chk("conflict_100", 32'(conflict_cnt), 32'd100);
      if (cyc == n + 507) chk("conflict_254", 32'(conflict_cnt), 32'd254);
      if (cyc == n + 509) chk("conflict_255", 32'(conflict_cnt), 32'd255);
    end
    chk("conflict_saturated", 32'(conflict_cnt), 32'd255);
    cpu_req = 1'b0;
    vid_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("conflict_hold_idle", 32'(conflict_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
